// File: rtl/io_out_pkg.sv
// Shared types and address map for the memory-mapped output port.
// Access-size codes, register offsets within the page, LCD strobe states.
package io_out_pkg;

  typedef enum logic [2:0] {
    F3Byte  = 3'b000,
    F3Half  = 3'b001,
    F3Word  = 3'b010,
    F3ByteU = 3'b100,
    F3HalfU = 3'b101
  } funct3_e;

  localparam logic [7:0] OFF_LEDR  = 8'h00;
  localparam logic [7:0] OFF_LEDG  = 8'h10;
  localparam logic [7:0] OFF_HEX   = 8'h20;
  localparam logic [7:0] OFF_LCD   = 8'h30;
  localparam logic [7:0] OFF_LCDST = 8'h34;

  typedef enum logic [1:0] {
    LcdIdle,
    LcdSetup,
    LcdPulse,
    LcdHold
  } lcd_state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/io_out_port_if.sv
// LSU-side load/store bus into the output port.
interface io_out_port_if;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic [2:0]  funct3;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wren, output funct3, input rdata);
  modport slave  (input addr, input wdata, input wren, input funct3, output rdata);
endinterface

// File: rtl/lcd_strobe_fsm.sv
// LCD write strobe: setup, enable pulse and hold phases timed by one shared down-counter.
module lcd_strobe_fsm
  import io_out_pkg::*;
#(
  parameter int unsigned SETUP = 2,
  parameter int unsigned PULSE = 25,
  parameter int unsigned HOLD  = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_en,
  output logic o_busy
);

  localparam int unsigned CntW = $clog2(max3(SETUP, PULSE, HOLD) + 1);

  lcd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LcdIdle: begin
        if (i_start) begin
          state_d = LcdSetup;
          cnt_d   = CntW'(SETUP);
        end
      end
      LcdSetup: begin
        if (cnt_q == CntW'(1)) begin
          state_d = LcdPulse;
          cnt_d   = CntW'(PULSE);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      LcdPulse: begin
        if (cnt_q == CntW'(1)) begin
          state_d = LcdHold;
          cnt_d   = CntW'(HOLD);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      LcdHold: begin
        if (cnt_q == CntW'(1)) begin
          state_d = LcdIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = LcdIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // EN comes straight from a flop so the pin never glitches on state decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LcdIdle;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == LcdPulse);
    end
  end

  assign o_en   = en_q;
  assign o_busy = (state_q != LcdIdle);

endmodule

// File: rtl/io_out_port.sv
// Memory-mapped LED/HEX/LCD output peripheral on the LSU path.
// Holds the board registers, decodes byte lanes, and muxes combinational read-back.
module io_out_port
  import io_out_pkg::*;
#(
  parameter logic [7:0]  BASE_HI   = 8'h70,
  parameter int unsigned LEDR_W    = 32,
  parameter int unsigned LEDG_W    = 32,
  parameter int unsigned NUM_HEX   = 8,
  parameter int unsigned LCD_SETUP = 2,
  parameter int unsigned LCD_PULSE = 25,
  parameter int unsigned LCD_HOLD  = 25
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  io_out_port_if.slave         bus,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  output logic                 o_lcd_busy
);

  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [NUM_HEX];
  logic [7:0]        lcd_data_q;
  logic              lcd_rs_q, lcd_rw_q, lcd_on_q, drop_q;

  logic [31:0] ledr_d, ledg_d, ledr_ext, ledg_ext, lcd_word, rdata;
  logic [6:0]  hex_d [NUM_HEX];
  logic [7:0]  cmd_data;
  logic        cmd_rs, cmd_rw, cmd_on, on_wr, lcd_hit, drop_clr;
  logic        lcd_start, drop_set, lcd_en, lcd_busy;

  logic       sel;
  logic [7:0] base;
  logic [3:0] size_mask, wr_lane;
  logic [7:0] lane_addr [4];
  logic [7:0] rb [4];

  // Lane base is the access address with its low bits cleared to natural alignment.
  always_comb begin
    sel       = (bus.addr[15:8] == BASE_HI);
    base      = bus.addr[7:0];
    size_mask = '0;
    case (funct3_e'(bus.funct3))
      F3Byte, F3ByteU: size_mask = 4'b0001;
      F3Half, F3HalfU: begin
        base[0]   = 1'b0;
        size_mask = 4'b0011;
      end
      F3Word: begin
        base[1:0] = 2'b00;
        size_mask = 4'b1111;
      end
      default: size_mask = '0;
    endcase
    for (int j = 0; j < 4; j++) begin
      lane_addr[j] = base + 8'(j);
      wr_lane[j]   = bus.wren && sel && size_mask[j];
    end
  end

  always_comb begin
    ledr_d   = 32'(ledr_q);
    ledg_d   = 32'(ledg_q);
    hex_d    = hex_q;
    cmd_data = '0;
    cmd_rs   = 1'b0;
    cmd_rw   = 1'b0;
    cmd_on   = 1'b0;
    on_wr    = 1'b0;
    lcd_hit  = 1'b0;
    drop_clr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (wr_lane[j]) begin
        if (lane_addr[j][7:2] == OFF_LEDR[7:2]) begin
          ledr_d[{lane_addr[j][1:0], 3'b000} +: 8] = bus.wdata[8*j +: 8];
        end else if (lane_addr[j][7:2] == OFF_LEDG[7:2]) begin
          ledg_d[{lane_addr[j][1:0], 3'b000} +: 8] = bus.wdata[8*j +: 8];
        end else if (lane_addr[j][7:4] == OFF_HEX[7:4]) begin
          for (int k = 0; k < NUM_HEX; k++) begin
            if (lane_addr[j] == OFF_HEX + 8'(k)) hex_d[k] = bus.wdata[8*j +: 7];
          end
        end else if (lane_addr[j][7:2] == OFF_LCD[7:2]) begin
          case (lane_addr[j][1:0])
            2'd0: begin
              cmd_data = bus.wdata[8*j +: 8];
              lcd_hit  = 1'b1;
            end
            2'd1: begin
              cmd_rs = bus.wdata[8*j];
              cmd_rw = bus.wdata[8*j+1];
            end
            2'd3: begin
              cmd_on = bus.wdata[8*j+7];
              on_wr  = 1'b1;
            end
            default: ;
          endcase
        end else if (lane_addr[j] == OFF_LCDST) begin
          drop_clr = bus.wdata[8*j+1];
        end
      end
    end
    lcd_start = lcd_hit && !lcd_busy;
    drop_set  = lcd_hit && lcd_busy;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '{default: '0};
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_on_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ledr_q <= ledr_d[LEDR_W-1:0];
      ledg_q <= ledg_d[LEDG_W-1:0];
      hex_q  <= hex_d;
      if (lcd_start) begin
        lcd_data_q <= cmd_data;
        lcd_rs_q   <= cmd_rs;
        lcd_rw_q   <= cmd_rw;
        if (on_wr) lcd_on_q <= cmd_on;
      end
      // A drop in the same cycle as a W1C keeps the flag set.
      if (drop_set) drop_q <= 1'b1;
      else if (drop_clr) drop_q <= 1'b0;
    end
  end

  lcd_strobe_fsm #(
    .SETUP (LCD_SETUP),
    .PULSE (LCD_PULSE),
    .HOLD  (LCD_HOLD)
  ) u_lcd_strobe_fsm (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (lcd_start),
    .o_en    (lcd_en),
    .o_busy  (lcd_busy)
  );

  assign ledr_ext = 32'(ledr_q);
  assign ledg_ext = 32'(ledg_q);
  assign lcd_word = {lcd_on_q, 20'b0, lcd_en, lcd_rw_q, lcd_rs_q, lcd_data_q};

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rb[j] = '0;
      if (lane_addr[j][7:2] == OFF_LEDR[7:2]) begin
        rb[j] = ledr_ext[{lane_addr[j][1:0], 3'b000} +: 8];
      end else if (lane_addr[j][7:2] == OFF_LEDG[7:2]) begin
        rb[j] = ledg_ext[{lane_addr[j][1:0], 3'b000} +: 8];
      end else if (lane_addr[j][7:4] == OFF_HEX[7:4]) begin
        for (int k = 0; k < NUM_HEX; k++) begin
          if (lane_addr[j] == OFF_HEX + 8'(k)) rb[j] = {1'b0, hex_q[k]};
        end
      end else if (lane_addr[j][7:2] == OFF_LCD[7:2]) begin
        rb[j] = lcd_word[{lane_addr[j][1:0], 3'b000} +: 8];
      end else if (lane_addr[j] == OFF_LCDST) begin
        rb[j] = {6'b0, drop_q, lcd_busy};
      end
    end
    rdata = '0;
    if (sel) begin
      case (funct3_e'(bus.funct3))
        F3Byte:  rdata = {{24{rb[0][7]}}, rb[0]};
        F3ByteU: rdata = {24'b0, rb[0]};
        F3Half:  rdata = {{16{rb[1][7]}}, rb[1], rb[0]};
        F3HalfU: rdata = {16'b0, rb[1], rb[0]};
        F3Word:  rdata = {rb[3], rb[2], rb[1], rb[0]};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) o_io_hex[7*k +: 7] = hex_q[k];
  end

  assign bus.rdata  = rdata;
  assign o_io_ledr  = ledr_q;
  assign o_io_ledg  = ledg_q;
  assign o_io_lcd   = lcd_word;
  assign o_lcd_busy = lcd_busy;

endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port: expected values queued at stimulus time, popped at sampling.
module tb_io_out_port;
  import io_out_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ledr, ledg, lcd;
  logic [55:0] hex;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  lcd_q[$];

  io_out_port_if bus_if ();

  io_out_port #(
    .BASE_HI   (8'h70),
    .LEDR_W    (32),
    .LEDG_W    (32),
    .NUM_HEX   (8),
    .LCD_SETUP (2),
    .LCD_PULSE (25),
    .LCD_HOLD  (25)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus_if),
    .o_io_ledr  (ledr),
    .o_io_ledg  (ledg),
    .o_io_hex   (hex),
    .o_io_lcd   (lcd),
    .o_lcd_busy (busy)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    bus_if.addr   = a;
    bus_if.wdata  = d;
    bus_if.funct3 = f3;
    bus_if.wren   = 1'b1;
    @(negedge clk);
    bus_if.wren   = 1'b0;
  endtask

  // Drives a load and queues the value the bench expects on rdata.
  task automatic issue_read(input logic [15:0] a, input logic [2:0] f3, input logic [31:0] e);
    @(negedge clk);
    bus_if.wren   = 1'b0;
    bus_if.addr   = a;
    bus_if.funct3 = f3;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] addrs [6];
    logic [31:0] e;
    addrs = '{16'h7000, 16'h7010, 16'h7020, 16'h7024, 16'h7030, 16'h7034};
    bus_if.addr = '0; bus_if.wdata = '0; bus_if.wren = 1'b0; bus_if.funct3 = 3'b010;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ledr, ledg, hex, lcd, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ledr=%h ledg=%h hex=%h lcd=%h busy=%b expected all 0",
               ledr, ledg, hex, lcd, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue_read(addrs[i], 3'b010, 32'h0);
      e = exp_q.pop_front();
      n_checks++;
      if (bus_if.rdata !== e) begin
        n_errors++;
        $display("FAIL reset_read @%h: got %h expected %h", addrs[i], bus_if.rdata, e);
      end
    end
  endtask

  task automatic test_ledr();
    logic [15:0] ra [5];
    logic [2:0]  rf [5];
    logic [31:0] re [5];
    logic [31:0] e;
    ra = '{16'h7001, 16'h7001, 16'h7000, 16'h7002, 16'h7003};
    rf = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    re = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'hFFFF_AB78, 32'h0000_1234, 32'h1234_AB78};
    bus_write(16'h7000, 32'h1234_5678, 3'b010);
    bus_write(16'h7001, 32'h0000_00AB, 3'b000);
    n_checks++;
    if (ledr !== 32'h1234_AB78) begin
      n_errors++;
      $display("FAIL ledr_value: got %h expected %h", ledr, 32'h1234_AB78);
    end
    for (int i = 0; i < 5; i++) begin
      issue_read(ra[i], rf[i], re[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus_if.rdata !== e) begin
        n_errors++;
        $display("FAIL ledr_read @%h f3=%b: got %h expected %h", ra[i], rf[i], bus_if.rdata, e);
      end
    end
  endtask

  task automatic test_ledg();
    logic [31:0] e;
    bus_write(16'h7010, 32'hCAFE_F00D, 3'b010);
    bus_write(16'h7013, 32'h0000_1234, 3'b001);
    n_checks++;
    if (ledg !== 32'h1234_F00D) begin
      n_errors++;
      $display("FAIL ledg_value: got %h expected %h", ledg, 32'h1234_F00D);
    end
    issue_read(16'h7012, 3'b101, 32'h0000_1234);
    e = exp_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== e) begin
      n_errors++;
      $display("FAIL ledg_read: got %h expected %h", bus_if.rdata, e);
    end
  endtask

  task automatic test_hex();
    logic [55:0] exp_hex;
    logic [15:0] ra [4];
    logic [2:0]  rf [4];
    logic [31:0] re [4];
    logic [31:0] e;
    ra = '{16'h7020, 16'h7027, 16'h7028, 16'h7024};
    rf = '{3'b010, 3'b100, 3'b000, 3'b010};
    re = '{32'h7F7F_0000, 32'h0000_007F, 32'h0000_0000, 32'h7F00_0000};
    exp_hex = '0;
    exp_hex[14 +: 14] = '1;
    bus_write(16'h7023, 32'h0000_FFFF, 3'b001);
    n_checks++;
    if (hex !== exp_hex) begin
      n_errors++;
      $display("FAIL hex_half: got %h expected %h", hex, exp_hex);
    end
    exp_hex[49 +: 7] = '1;
    bus_write(16'h7027, 32'h0000_00FF, 3'b000);
    bus_write(16'h7028, 32'h0000_005A, 3'b000);
    n_checks++;
    if (hex !== exp_hex) begin
      n_errors++;
      $display("FAIL hex_bytes: got %h expected %h", hex, exp_hex);
    end
    for (int i = 0; i < 4; i++) begin
      issue_read(ra[i], rf[i], re[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus_if.rdata !== e) begin
        n_errors++;
        $display("FAIL hex_read @%h f3=%b: got %h expected %h", ra[i], rf[i], bus_if.rdata, e);
      end
    end
  endtask

  task automatic test_lcd_engine();
    logic [1:0]  le;
    logic [31:0] e;
    for (int c = 1; c <= 55; c++) lcd_q.push_back({(c >= 3 && c <= 27), (c <= 52)});
    bus_write(16'h7030, 32'h8000_0141, 3'b010);
    for (int c = 1; c <= 55; c++) begin
      le = lcd_q.pop_front();
      n_checks++;
      if ({lcd[10], busy} !== le) begin
        n_errors++;
        $display("FAIL lcd_timing cycle %0d: en,busy=%b%b expected %b", c, lcd[10], busy, le);
      end
      if (c == 11) begin
        n_checks++;
        if (lcd !== 32'h8000_0541) begin
          n_errors++;
          $display("FAIL lcd_shadow_busy: got %h expected %h", lcd, 32'h8000_0541);
        end
      end
      if (c == 10) begin
        bus_if.addr = 16'h7030; bus_if.wdata = 32'h0000_0255;
        bus_if.funct3 = 3'b010; bus_if.wren = 1'b1;
      end else if (c == 12) begin
        bus_if.wren = 1'b0; bus_if.addr = 16'h7034; bus_if.funct3 = 3'b100;
        exp_q.push_back(32'h3);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (bus_if.rdata !== e) begin
          n_errors++;
          $display("FAIL lcd_status_busy: got %h expected %h", bus_if.rdata, e);
        end
      end else begin
        bus_if.wren = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (lcd !== 32'h8000_0141) begin
      n_errors++;
      $display("FAIL lcd_shadow_idle: got %h expected %h", lcd, 32'h8000_0141);
    end
    issue_read(16'h7034, 3'b100, 32'h2);
    e = exp_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== e) begin
      n_errors++;
      $display("FAIL lcd_status_idle: got %h expected %h", bus_if.rdata, e);
    end
    bus_write(16'h7034, 32'h0000_0002, 3'b000);
    issue_read(16'h7034, 3'b010, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== e) begin
      n_errors++;
      $display("FAIL lcd_status_w1c: got %h expected %h", bus_if.rdata, e);
    end
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(16'h7030, 32'h8000_0141, 3'b010);
    repeat (4) @(negedge clk);
    n_checks++;
    if ({lcd[10], busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL mid_pulse_pre: en,busy=%b%b expected 11", lcd[10], busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ledr, ledg, hex, lcd, busy} !== '0) begin
      n_errors++;
      $display("FAIL mid_pulse_reset: ledr=%h ledg=%h hex=%h lcd=%h busy=%b expected all 0",
               ledr, ledg, hex, lcd, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unmapped();
    logic [31:0] e;
    bus_write(16'h6000, 32'hFFFF_FFFF, 3'b010);
    bus_write(16'h6010, 32'hFFFF_FFFF, 3'b010);
    bus_write(16'h6030, 32'h8000_0141, 3'b010);
    bus_write(16'h7040, 32'hFFFF_FFFF, 3'b010);
    n_checks++;
    if ({ledr, ledg, hex, lcd, busy} !== '0) begin
      n_errors++;
      $display("FAIL unmapped_write: ledr=%h ledg=%h hex=%h lcd=%h busy=%b expected all 0",
               ledr, ledg, hex, lcd, busy);
    end
    bus_write(16'h7000, 32'h0000_00C3, 3'b010);
    issue_read(16'h6000, 3'b010, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== e) begin
      n_errors++;
      $display("FAIL unmapped_read: got %h expected %h", bus_if.rdata, e);
    end
    issue_read(16'h7000, 3'b011, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== e) begin
      n_errors++;
      $display("FAIL bad_funct3_read: got %h expected %h", bus_if.rdata, e);
    end
  endtask

  initial begin
    test_reset();
    test_ledr();
    test_ledg();
    test_hex();
    test_lcd_engine();
    test_reset_mid_pulse();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
